alu32_arbiter: RTL

Two-requester arbiter and sequencer for the shared 32-bit combinational ALU (x, y, 5-bit control, cin → 32-bit out, overflow). Each requester issues one operation through a valid/ready request channel and receives the result through a valid/ready response channel. The block grants the ALU round-robin, registers the operands, waits a configurable settle time, captures the result, and returns it to the granted requester. It sits between the ALU instance and its client blocks, and it is the only driver of the ALU inputs.

---
 rtl/alu32_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu32_arbiter.sv
// Round-robin arbiter/sequencer giving two requesters turns on a shared 32-bit ALU.
// Optional sticky per-requester overflow flags: define ALU32_ARB_STICKY_OVF_EN.
module alu32_arbiter #(
    parameter int ALU_LATENCY = 1
) (
    input  logic        Input_clk,
    input  logic        Input_rst_n,
    input  logic        Input_req0_valid,
    input  logic [31:0] Input_req0_x,
    input  logic [31:0] Input_req0_y,
    input  logic [4:0]  Input_req0_control,
    input  logic        Input_req0_cin,
    output logic        monitor_req0_ready,
    output logic        monitor_rsp0_valid,
    output logic [31:0] monitor_rsp0_out,
    output logic        monitor_rsp0_overflow,
    input  logic        Input_rsp0_ready,
    input  logic        Input_req1_valid,
    input  logic [31:0] Input_req1_x,
    input  logic [31:0] Input_req1_y,
    input  logic [4:0]  Input_req1_control,
    input  logic        Input_req1_cin,
    output logic        monitor_req1_ready,
    output logic        monitor_rsp1_valid,
    output logic [31:0] monitor_rsp1_out,
    output logic        monitor_rsp1_overflow,
    input  logic        Input_rsp1_ready,
    output logic [31:0] monitor_alu_x,
    output logic [31:0] monitor_alu_y,
    output logic [4:0]  monitor_alu_control,
    output logic        monitor_alu_cin,
    input  logic [31:0] Input_alu_out,
    input  logic        Input_alu_overflow,
    output logic        monitor_busy,
    input  logic        Input_ovf_clr,
    output logic [1:0]  monitor_ovf_sticky
);

    localparam logic [3:0] CNT_LOAD = 4'(ALU_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic        last;
    logic        owner;
    logic        grant;
    logic        accept;
    logic        rsp_accept;
    logic [3:0]  cnt;
    logic [31:0] rsp_out;
    logic        rsp_ovf;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant = 1'b0;
        if (Input_req0_valid && Input_req1_valid)
            grant = ~last;
        else if (Input_req1_valid)
            grant = 1'b1;
    end

    // Ready is gated by reset so nothing can be accepted while it is asserted.
    assign monitor_req0_ready = Input_rst_n && (state == IDLE) && Input_req0_valid && !grant;
    assign monitor_req1_ready = Input_rst_n && (state == IDLE) && Input_req1_valid && grant;
    assign accept     = monitor_req0_ready || monitor_req1_ready;
    assign rsp_accept = (state == RESP) && (owner ? Input_rsp1_ready : Input_rsp0_ready);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    if (cnt == 4'd0) state_next = RESP;
            RESP:    if (rsp_accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Input_clk) begin
        if (!Input_rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge Input_clk) begin
        if (!Input_rst_n) begin
            last                <= 1'b1;
            owner               <= 1'b0;
            cnt                 <= 4'd0;
            monitor_alu_x       <= '0;
            monitor_alu_y       <= '0;
            monitor_alu_control <= '0;
            monitor_alu_cin     <= 1'b0;
            rsp_out             <= '0;
            rsp_ovf             <= 1'b0;
        end else begin
            if (accept) begin
                last                <= grant;
                owner               <= grant;
                cnt                 <= CNT_LOAD;
                monitor_alu_x       <= grant ? Input_req1_x       : Input_req0_x;
                monitor_alu_y       <= grant ? Input_req1_y       : Input_req0_y;
                monitor_alu_control <= grant ? Input_req1_control : Input_req0_control;
                monitor_alu_cin     <= grant ? Input_req1_cin     : Input_req0_cin;
            end else if (state == EXEC && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == EXEC && cnt == 4'd0) begin
                rsp_out <= Input_alu_out;
                rsp_ovf <= Input_alu_overflow;
            end
        end
    end

    assign monitor_busy          = (state != IDLE);
    assign monitor_rsp0_valid    = (state == RESP) && !owner;
    assign monitor_rsp1_valid    = (state == RESP) && owner;
    assign monitor_rsp0_out      = rsp_out;
    assign monitor_rsp1_out      = rsp_out;
    assign monitor_rsp0_overflow = rsp_ovf;
    assign monitor_rsp1_overflow = rsp_ovf;

`ifdef ALU32_ARB_STICKY_OVF_EN
    logic [1:0] ovf_set;

    assign ovf_set = {rsp_accept && owner && rsp_ovf, rsp_accept && !owner && rsp_ovf};

    // A set in the same cycle as a clear survives the clear.
    always_ff @(posedge Input_clk) begin
        if (!Input_rst_n)
            monitor_ovf_sticky <= 2'b00;
        else
            monitor_ovf_sticky <= (Input_ovf_clr ? 2'b00 : monitor_ovf_sticky) | ovf_set;
    end
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr     = Input_ovf_clr;
    assign monitor_ovf_sticky = 2'b00;
`endif

endmodule
